// File: rtl/sdr_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// The SDR_ARB_RR_EN build macro switches requesters 1..NUM_REQ-1 to round robin.
package sdr_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam int unsigned SDR_ARB_LOADER_IDX = 0;
  localparam int unsigned SDR_BE_W           = 2;
  localparam logic [SDR_BE_W-1:0] SDR_BE_FULL = 2'b11;

endpackage

// File: rtl/sdr_port_arbiter_if.sv
// SDRAM controller channel: level-held sdr_req with a one-cycle sdr_rdy completion.
interface sdr_port_arbiter_if
  import sdr_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 16
) ();

  logic [ADDR_W-1:0]   sdr_addr;
  logic [DATA_W-1:0]   sdr_data;
  logic [SDR_BE_W-1:0] sdr_be;
  logic                sdr_we;
  logic                sdr_req;
  logic                sdr_rdy;
  logic [DATA_W-1:0]   rd_data;

  modport master (
    output sdr_addr, sdr_data, sdr_be, sdr_we, sdr_req,
    input  sdr_rdy, rd_data
  );

  modport slave (
    input  sdr_addr, sdr_data, sdr_be, sdr_we, sdr_req,
    output sdr_rdy, rd_data
  );

endinterface

// File: rtl/sdr_arb_pick.sv
// Combinational winner select: loader first, then fixed or round-robin order.
// The SDR_ARB_RR_EN macro enables the pointer-based search.
module sdr_arb_pick
  import sdr_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
`ifdef SDR_ARB_RR_EN
  , parameter int unsigned IDX_W = $clog2(NUM_REQ)
`endif
) (
  input  logic [NUM_REQ-1:0] elig_i,
`ifdef SDR_ARB_RR_EN
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_c,
`endif
  output logic [NUM_REQ-1:0] grant_c,
  output logic               valid_c
);

  // Loader wins outright; otherwise scan from the pointer upward, then wrap from 1.
  always_comb begin
    grant_c = '0;
    valid_c = 1'b0;
`ifdef SDR_ARB_RR_EN
    idx_c   = '0;
`endif
    if (elig_i[SDR_ARB_LOADER_IDX]) begin
      grant_c[SDR_ARB_LOADER_IDX] = 1'b1;
      valid_c = 1'b1;
`ifdef SDR_ARB_RR_EN
      idx_c   = IDX_W'(SDR_ARB_LOADER_IDX);
`endif
    end else begin
`ifdef SDR_ARB_RR_EN
      for (int i = 1; i < NUM_REQ; i++) begin
        if (!valid_c && elig_i[i] && (IDX_W'(i) >= ptr_i)) begin
          grant_c[i] = 1'b1;
          valid_c    = 1'b1;
          idx_c      = IDX_W'(i);
        end
      end
`endif
      for (int i = 1; i < NUM_REQ; i++) begin
        if (!valid_c && elig_i[i]) begin
          grant_c[i] = 1'b1;
          valid_c    = 1'b1;
`ifdef SDR_ARB_RR_EN
          idx_c      = IDX_W'(i);
`endif
        end
      end
    end
  end

endmodule

// File: rtl/sdr_port_arbiter.sv
// Shares one SDRAM controller channel among NUM_REQ requesters (index 0 = ROM loader).
// Define SDR_ARB_RR_EN for round robin among the non-loader requesters.
module sdr_port_arbiter
  import sdr_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         loading,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ*SDR_BE_W-1:0]  req_be,
  output logic [NUM_REQ-1:0]           ack,
  output logic [DATA_W-1:0]            rdata,
  output logic                         busy,
  sdr_port_arbiter_if.master           sdr
);

  localparam logic [NUM_REQ-1:0] LOADER_MASK = NUM_REQ'(1) << SDR_ARB_LOADER_IDX;
`ifdef SDR_ARB_RR_EN
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
`endif

  arb_state_t          state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   sdr_addr_q;
  logic [DATA_W-1:0]   sdr_data_q;
  logic [SDR_BE_W-1:0] sdr_be_q;
  logic                sdr_we_q;
  logic                sdr_req_q;
  logic                busy_q;
`ifdef SDR_ARB_RR_EN
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    pick_idx_c;
`endif

  logic [NUM_REQ-1:0]  elig_c;
  logic [NUM_REQ-1:0]  pick_grant_c;
  logic                pick_valid_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic [SDR_BE_W-1:0] sel_be_c;
  logic                sel_we_c;

  assign elig_c = loading ? (req & LOADER_MASK) : req;

  sdr_arb_pick #(
    .NUM_REQ (NUM_REQ)
`ifdef SDR_ARB_RR_EN
    , .IDX_W (IDX_W)
`endif
  ) u_pick (
    .elig_i  (elig_c),
`ifdef SDR_ARB_RR_EN
    .ptr_i   (ptr_q),
    .idx_c   (pick_idx_c),
`endif
    .grant_c (pick_grant_c),
    .valid_c (pick_valid_c)
  );

  // One-hot payload mux from the winning requester's slices.
  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    sel_be_c   = '0;
    sel_we_c   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant_c[i]) begin
        sel_addr_c = req_addr[i*ADDR_W +: ADDR_W];
        sel_data_c = req_data[i*DATA_W +: DATA_W];
        sel_be_c   = req_be[i*SDR_BE_W +: SDR_BE_W];
        sel_we_c   = req_we[i];
      end
    end
  end

  // Transfer FSM; DONE gives the acked requester one cycle to drop req before re-arbitration.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      sdr_addr_q <= '0;
      sdr_data_q <= '0;
      sdr_be_q   <= '0;
      sdr_we_q   <= 1'b0;
      sdr_req_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SDR_ARB_RR_EN
      ptr_q      <= IDX_W'(1);
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid_c) begin
            gnt_q      <= pick_grant_c;
            sdr_addr_q <= sel_addr_c;
            sdr_data_q <= sel_data_c;
            sdr_be_q   <= sel_we_c ? sel_be_c : SDR_BE_FULL;
            sdr_we_q   <= sel_we_c;
            sdr_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ARB_WAIT;
`ifdef SDR_ARB_RR_EN
            if (pick_idx_c != IDX_W'(SDR_ARB_LOADER_IDX)) begin
              ptr_q <= (pick_idx_c == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1)
                                                            : pick_idx_c + IDX_W'(1);
            end
`endif
          end
        end
        ARB_WAIT: begin
          if (sdr.sdr_rdy) begin
            sdr_req_q <= 1'b0;
            ack_q     <= gnt_q;
            if (!sdr_we_q) rdata_q <= sdr.rd_data;
            state_q   <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: begin
          sdr_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign sdr.sdr_addr = sdr_addr_q;
  assign sdr.sdr_data = sdr_data_q;
  assign sdr.sdr_be   = sdr_be_q;
  assign sdr.sdr_we   = sdr_we_q;
  assign sdr.sdr_req  = sdr_req_q;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Bench for sdr_port_arbiter: acts as requesters and SDRAM controller, checks against a transaction model.
// Build with +define+SDR_ARB_RR_EN to check the round-robin variant.
module tb_sdr_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 24;
  localparam int DW = 16;

  logic             sys_clk = 1'b0;
  logic             reset_n;
  logic             loading;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR*2-1:0]  req_be;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    rdata;
  logic             busy;

  sdr_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sdr_if ();

  sdr_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .loading  (loading),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_be   (req_be),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .sdr      (sdr_if.master)
  );

  always #5 sys_clk = ~sys_clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            m_ptr;
  logic [DW-1:0] m_rdata;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rules: loader first, loading locks out the rest, then fixed or RR order.
  function automatic int model_pick(input logic [NR-1:0] r, input logic ld, input int p);
    if (r[0]) return 0;
    if (ld) return -1;
`ifdef SDR_ARB_RR_EN
    for (int k = 0; k < NR - 1; k++) begin
      int j;
      j = 1 + ((p - 1 + k) % (NR - 1));
      if (r[j]) return j;
    end
`else
    for (int j = 1; j < NR; j++) if (r[j]) return j;
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] be);
    req[i]               = 1'b1;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_be[i*2 +: 2]     = be;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, 1'($urandom), {4'(i), 20'($urandom)}, 16'($urandom), 2'($urandom));
  endtask

  // One transfer expected for requester w; d extra WAIT cycles before sdr_rdy.
  task automatic do_xfer(input int w, input int d, input logic [DW-1:0] rdv,
                         input bit drop_mid, input bit load_mid, input bit hold);
    int            cnt;
    logic          we;
    logic [NR-1:0] onehot;
    we     = req_we[w];
    onehot = NR'(1) << w;
    cnt    = 0;
    do begin
      tick();
      cnt++;
    end while (!sdr_if.sdr_req && cnt < 8);
    chk("grant_latency", 32'(cnt), 32'd1);
    chk("sdr_addr", 32'(sdr_if.sdr_addr), 32'(req_addr[w*AW +: AW]));
    chk("sdr_we", 32'(sdr_if.sdr_we), 32'(we));
    chk("sdr_be", 32'(sdr_if.sdr_be), we ? 32'(req_be[w*2 +: 2]) : 32'h3);
    if (we) chk("sdr_data", 32'(sdr_if.sdr_data), 32'(req_data[w*DW +: DW]));
    chk("busy_wait", 32'(busy), 32'd1);
    if (drop_mid) req[w] = 1'b0;
    if (load_mid) loading = 1'b1;
    for (int k = 0; k < d; k++) begin
      tick();
      chk("req_hold", 32'(sdr_if.sdr_req), 32'd1);
      chk("no_early_ack", 32'(ack), 32'd0);
    end
    sdr_if.rd_data = rdv;
    sdr_if.sdr_rdy = 1'b1;
    tick();
    sdr_if.sdr_rdy = 1'b0;
    sdr_if.rd_data = 16'($urandom);
    if (!we) m_rdata = rdv;
    chk("ack_pulse", 32'(ack), 32'(onehot));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("req_drop", 32'(sdr_if.sdr_req), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    if (!hold) req[w] = 1'b0;
    tick();
    chk("ack_clear", 32'(ack), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    req[w] = 1'b0;
    if (w != 0) m_ptr = (w == NR - 1) ? 1 : w + 1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * NR; k++) begin
      int w;
      w = model_pick(req, loading, m_ptr);
      if (w < 0) break;
      do_xfer(w, $urandom_range(0, 2), 16'($urandom), 1'b0, 1'b0, 1'b0);
    end
    chk("drained", 32'(sdr_if.sdr_req), 32'd0);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    loading        = 1'b0;
    req            = '0;
    sdr_if.sdr_rdy = 1'b0;
    repeat (2) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_sdr_req", 32'(sdr_if.sdr_req), 32'd0);
    chk("rst_sdr_we", 32'(sdr_if.sdr_we), 32'd0);
    chk("rst_sdr_be", 32'(sdr_if.sdr_be), 32'd0);
    chk("rst_sdr_addr", 32'(sdr_if.sdr_addr), 32'd0);
    chk("rst_sdr_data", 32'(sdr_if.sdr_data), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    m_ptr   = 1;
    m_rdata = '0;
  endtask

  initial begin
    int  w;
    bit  seen;
    req_we         = '0;
    req_addr       = '0;
    req_data       = '0;
    req_be         = '0;
    sdr_if.rd_data = '0;
    do_reset();

    // sdr_rdy while idle is ignored
    sdr_if.sdr_rdy = 1'b1;
    tick();
    sdr_if.sdr_rdy = 1'b0;
    tick();
    chk("idle_rdy_ack", 32'(ack), 32'd0);
    chk("idle_rdy_busy", 32'(busy), 32'd0);

    // Reset mid-WAIT abandons the transfer without ack
    set_req(2, 1'b0, 24'h001234, 16'h0, 2'b00);
    tick();
    chk("t1_granted", 32'(sdr_if.sdr_req), 32'd1);
    chk("t1_addr", 32'(sdr_if.sdr_addr), 32'h001234);
    reset_n = 1'b0;
    tick();
    chk("t1_req_low", 32'(sdr_if.sdr_req), 32'd0);
    chk("t1_no_ack", 32'(ack), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    req = '0;
    reset_n = 1'b1;
    m_ptr = 1;
    m_rdata = '0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (ack != '0 || sdr_if.sdr_req) seen = 1'b1;
    end
    chk("t1_quiet", 32'(seen), 32'd0);

    // Single write with sdr_rdy in cycle 4
    set_req(0, 1'b1, 24'h000010, 16'hA55A, 2'b01);
    do_xfer(0, 3, 16'h1111, 1'b0, 1'b0, 1'b0);

    // Read return
    set_req(3, 1'b0, 24'h3ABCDE, 16'h0, 2'b00);
    do_xfer(3, 0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    chk("t5_rdata_hold", 32'(rdata), 32'hBEEF);

    // Loading lock-out
    loading = 1'b1;
    for (int i = 1; i < NR; i++) set_rand_req(i);
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (sdr_if.sdr_req) seen = 1'b1;
    end
    chk("t3_locked", 32'(seen), 32'd0);
    set_rand_req(0);
    do_xfer(model_pick(req, loading, m_ptr), 1, 16'h2222, 1'b0, 1'b0, 1'b0);
    loading = 1'b0;
    drain();

    // Loading rising mid-WAIT: current completes, no further non-loader grant
    set_rand_req(1);
    set_rand_req(2);
    do_xfer(model_pick(req, loading, m_ptr), 1, 16'h3333, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (sdr_if.sdr_req) seen = 1'b1;
    end
    chk("loadmid_lock", 32'(seen), 32'd0);
    loading = 1'b0;
    drain();

    // Priority from reset: 0,1,3 then contention between 1 and 3
    do_reset();
    set_rand_req(0);
    set_rand_req(1);
    set_rand_req(3);
    drain();
    set_rand_req(1);
    set_rand_req(3);
    for (int k = 0; k < 4; k++) begin
      w = model_pick(req, loading, m_ptr);
      do_xfer(w, 0, 16'($urandom), 1'b0, 1'b0, 1'b0);
      set_rand_req(w);
    end
    drain();

    // Request held through the ack cycle is not serviced twice
    set_rand_req(1);
    do_xfer(1, 0, 16'h4444, 1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (sdr_if.sdr_req) seen = 1'b1;
    end
    chk("t6_no_dup", 32'(seen), 32'd0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) set_rand_req(i);
      loading = ($urandom_range(0, 4) == 0);
      w = model_pick(req, loading, m_ptr);
      if (w < 0) begin
        repeat (2) tick();
        chk("rand_no_grant", 32'(sdr_if.sdr_req), 32'd0);
      end else begin
        do_xfer(w, $urandom_range(0, 3), 16'($urandom), ($urandom_range(0, 3) == 0),
                (w != 0) && ($urandom_range(0, 4) == 0), 1'b0);
      end
    end
    loading = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
